// File: rtl/fifo_frame_reader.sv
// Drains a framed burst from the read side of an 8-deep FIFO onto a valid/ready stream.
// A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency so the stream sustains 1 word/cycle.
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   rd_rem;
    logic [LEN_WIDTH-1:0]   out_rem;
    logic                   inflight;
    logic [1:0]             occ;
    logic [DATA_WIDTH-1:0]  skid0;
    logic [DATA_WIDTH-1:0]  skid1;
    logic [1:0]             pending;
    logic                   room;
    logic                   pop;

    // Stream handshake: a word transfers on any cycle with m_valid & m_ready; while
    // m_valid is high and m_ready low, m_data and m_last hold their values.
    assign m_valid = (occ != 2'd0);
    assign m_data  = skid0;
    assign m_last  = m_valid & (out_rem == LEN_WIDTH'(1));
    assign pop     = m_valid & m_ready;
    assign busy    = (state != IDLE);

    // A word in flight from the FIFO already owns a skid slot, so it counts toward occupancy.
    assign pending = occ + {1'b0, inflight};
    assign room    = (pending < 2'd2) | ((pending == 2'd2) & pop);
    assign fifo_rd = (state == RUN) & ~fifo_empty & (rd_rem != '0) & room;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_rem   <= '0;
            out_rem  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= fifo_rd;

            if (fifo_rd) begin
                rd_rem <= rd_rem - LEN_WIDTH'(1);
            end
            if (pop && (out_rem != '0)) begin
                out_rem <= out_rem - LEN_WIDTH'(1);
            end

            // Push of the landing FIFO word never meets a full buffer: the read gate guarantees it.
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid0 <= fifo_q;
                    end else begin
                        skid1 <= fifo_q;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= fifo_q;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= fifo_q;
                    end
                end
                default: begin
                end
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        if (frame_len != '0) begin
                            rd_rem  <= frame_len;
                            out_rem <= frame_len;
                            state   <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fifo_rd && (rd_rem == LEN_WIDTH'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (out_rem == LEN_WIDTH'(1))) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: array-backed FIFO model, frame-level scoreboard checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_fifo_frame_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] frame_len;
    logic          busy;
    logic          done;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_q = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    fifo_frame_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_q(fifo_q), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- FIFO read-side model ----------------
    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          stall  = 1'b0;

    assign fifo_empty = stall || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd && rd_ptr < 256) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // ---------------- scoreboard / model state ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            rd_cyc_q[$];
    int            pop_cyc_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int pop_cnt  = 0;
    int done_cnt = 0;
    int last_cnt = 0;
    int valid_cnt = 0;

    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    int            m_flen = 0;
    int            m_reads = 0;
    int            m_pops = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] held = '0;
    logic          popped;
    logic          nb;
    logic          nd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One compare process, one cycle per pass, sampled 1 time unit before the rising edge.
    always @(negedge clk) begin
        #4;
        cyc++;
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_fifo_rd", fifo_rd, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            m_busy = 1'b0;
            m_done = 1'b0;
            m_reads = 0;
            m_pops = 0;
            m_flen = 0;
            hold_prev = 1'b0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (done) done_cnt++;
            if (!m_busy) begin
                chk("idle_fifo_rd", fifo_rd, 0);
                chk("idle_m_valid", m_valid, 0);
            end
            if (fifo_rd) begin
                chk("rd_while_empty", fifo_empty, 0);
                m_reads++;
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
                chk("reads_within_frame", m_reads <= m_flen, 1);
            end
            if (hold_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, held);
            end
            popped = 1'b0;
            if (m_valid) begin
                valid_cnt++;
                chk("m_last", m_last, (m_pops + 1) == m_flen);
                if (m_ready) begin
                    if (exp_q.size() == 0) chk("word_expected", 0, 1);
                    else chk("m_data", m_data, exp_q.pop_front());
                    got_q.push_back(m_data);
                    pop_cyc_q.push_back(cyc);
                    if (m_last) last_cnt++;
                    m_pops++;
                    pop_cnt++;
                    popped = 1'b1;
                end
            end else begin
                chk("m_last_no_valid", m_last, 0);
            end
            chk("buffered_le_2", (m_reads - m_pops) <= 2, 1);
            hold_prev = m_valid && !m_ready;
            held = m_data;

            nb = m_busy;
            nd = 1'b0;
            if (m_busy && popped && m_pops == m_flen) begin
                nb = 1'b0;
                nd = 1'b1;
            end
            if (!m_busy && start) begin
                if (frame_len == 0) begin
                    nd = 1'b1;
                end else begin
                    nb = 1'b1;
                    m_flen = int'(frame_len);
                    m_reads = 0;
                    m_pops = 0;
                end
            end
            m_busy = nb;
            m_done = nd;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start = 1'b1;
        frame_len = LW'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, done_cnt != d0, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int r0, p0, g0, q0, c0, d0, l0, v0, n, len;
        rst = 1'b1;
        start = 1'b0;
        frame_len = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: four words, sink always ready
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        m_ready = 1'b1;
        r0 = rd_cnt; g0 = got_q.size(); q0 = rd_cyc_q.size(); c0 = pop_cyc_q.size();
        d0 = done_cnt; l0 = last_cnt;
        do_start(4);
        wait_done("t1_done_seen", 40);
        repeat (2) @(negedge clk);
        chk("t1_reads", rd_cnt - r0, 4);
        chk("t1_words", got_q.size() - g0, 4);
        if (got_q.size() >= g0 + 4 && rd_cyc_q.size() >= q0 + 4 && pop_cyc_q.size() >= c0 + 4) begin
            chk("t1_rd_back_to_back", rd_cyc_q[q0+3] - rd_cyc_q[q0], 3);
            chk("t1_pop_back_to_back", pop_cyc_q[c0+3] - pop_cyc_q[c0], 3);
            chk("t1_first_word", got_q[g0], 8'h11);
            chk("t1_last_word", got_q[g0+3], 8'h44);
        end
        chk("t1_last_count", last_cnt - l0, 1);
        chk("t1_done_count", done_cnt - d0, 1);

        // 2: six-word frame from a full FIFO with a stalled sink
        for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i));
        m_ready = 1'b0;
        r0 = rd_cnt; p0 = pop_cnt; g0 = got_q.size();
        do_start(6);
        repeat (4) @(negedge clk);
        chk("t2_reads_while_stalled_le_2", (rd_cnt - r0) <= 2, 1);
        chk("t2_no_pop_while_stalled", pop_cnt - p0, 0);
        m_ready = 1'b1;
        wait_done("t2_done_seen", 60);
        chk("t2_pops", pop_cnt - p0, 6);
        if (got_q.size() >= g0 + 6) begin
            chk("t2_first_word", got_q[g0], 8'hA0);
            chk("t2_sixth_word", got_q[g0+5], 8'hA5);
        end

        // 3: eight-word frame with fifo_empty forced high 2 cycles of every 4
        for (int i = 0; i < 6; i++) load(8'hB0 + 8'(i));
        p0 = pop_cnt; g0 = got_q.size(); d0 = done_cnt; l0 = last_cnt;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            start = (n == 0);
            frame_len = 8'd8;
            if (n % 2 == 0) stall = ~stall;
            n++;
        end
        start = 1'b0;
        stall = 1'b0;
        chk("t3_done_seen", done_cnt != d0, 1);
        chk("t3_pops", pop_cnt - p0, 8);
        chk("t3_last_count", last_cnt - l0, 1);
        if (got_q.size() >= g0 + 8) begin
            chk("t3_first_word", got_q[g0], 8'hA6);
            chk("t3_third_word", got_q[g0+2], 8'hB0);
            chk("t3_last_word", got_q[g0+7], 8'hB5);
        end

        // 4: zero-length frame
        repeat (2) @(negedge clk);
        r0 = rd_cnt; v0 = valid_cnt; d0 = done_cnt;
        do_start(0);
        repeat (3) @(negedge clk);
        chk("t4_done_count", done_cnt - d0, 1);
        chk("t4_no_reads", rd_cnt - r0, 0);
        chk("t4_no_valid", valid_cnt - v0, 0);

        // 5: start while busy is ignored
        for (int i = 0; i < 5; i++) load(8'hC0 + 8'(i));
        p0 = pop_cnt; g0 = got_q.size(); d0 = done_cnt; l0 = last_cnt;
        do_start(5);
        @(negedge clk);
        start = 1'b1;
        frame_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done_seen", 40);
        repeat (3) @(negedge clk);
        chk("t5_pops", pop_cnt - p0, 5);
        chk("t5_last_count", last_cnt - l0, 1);
        chk("t5_done_count", done_cnt - d0, 1);
        if (got_q.size() >= g0 + 5) chk("t5_last_word", got_q[g0+4], 8'hC4);

        // 6: reset after two words emitted, then a fresh frame
        for (int i = 0; i < 5; i++) load(8'hD0 + 8'(i));
        p0 = pop_cnt;
        do_start(5);
        n = 0;
        while ((pop_cnt - p0) < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t6_two_words_before_reset", pop_cnt - p0, 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(mem[i]);
        load(8'hE0); load(8'hE1); load(8'hE2);
        len = wr_ptr - rd_ptr;
        p0 = pop_cnt; g0 = got_q.size(); l0 = last_cnt;
        do_start(len);
        wait_done("t6_done_seen", 40);
        chk("t6_pops", pop_cnt - p0, len);
        chk("t6_last_count", last_cnt - l0, 1);
        if (got_q.size() >= g0 + 1) chk("t6_final_word", got_q[got_q.size()-1], 8'hE2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
